priv_sleep_ctrl: RTL
====================

PRIV_SLEEP_CTRL -- requirements
Module: priv_sleep_ctrl

Interface
REQ-001 SHALL have parameter: WFI_FLUSH_CYCLES, 2, pipeline-drain cycles between WFI acceptance and sleep; legal range 1..15.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_ni  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: insn_valid_i  input  1  decoded instruction present this cycle.
REQ-005 SHALL have port: mret_insn_i  input  1  presented instruction is MRET.
REQ-006 SHALL have port: wfi_insn_i  input  1  presented instruction is WFI.
REQ-007 SHALL have port: csr_mstatus_tw_i  input  1  mstatus.TW; trap WFI outside M-Mode.
REQ-008 SHALL have port: csr_mstatus_mpp_i  input  2  mstatus.MPP; mode restored by MRET.
REQ-009 SHALL have port: irq_pending_i  input  1  enabled interrupt pending (level).
REQ-010 SHALL have port: insn_ready_o  output  1  controller accepts the presented instruction.
REQ-011 SHALL have port: priv_mode_o  output  2  current privilege level (2'b11 M, 2'b00 U).
REQ-012 SHALL have port: illegal_umode_o  output  1  one-cycle pulse: privileged instruction executed outside M-Mode.
REQ-013 SHALL have port: trap_req_o  output  1  one-cycle pulse: illegal-instruction trap request.
REQ-014 SHALL have port: flush_o  output  1  pipeline flush request while draining for WFI.
REQ-015 SHALL have port: core_sleep_o  output  1  core clock may be gated.

Function
REQ-016 SHALL implement FSM states RUN, FLUSH, SLEEP, WAKE; insn_ready_o = 1 only in RUN.
REQ-017 SHALL accept an instruction on a cycle where insn_valid_i and insn_ready_o are both 1; inputs on other cycles are ignored.
REQ-018 SHALL classify an accepted instruction illegal when priv_mode_o != 2'b11 and (mret_insn_i or (csr_mstatus_tw_i and wfi_insn_i)).
REQ-019 On illegal accept: illegal_umode_o and trap_req_o = 1 for exactly the following cycle, priv_mode_o <= 2'b11 next cycle, FSM remains RUN.
REQ-020 On legal MRET accept: priv_mode_o <= 2'b11 if csr_mstatus_mpp_i == 2'b11, else 2'b00, effective next cycle.
REQ-021 On legal WFI accept: FSM -> FLUSH next cycle, drain counter (4 bits) loaded with WFI_FLUSH_CYCLES-1.
REQ-022 When mret_insn_i and wfi_insn_i are both 1 on a legal accept, MRET SHALL take priority and WFI is ignored.
REQ-023 FLUSH: flush_o = 1; counter decrements each cycle; at count 0 -> SLEEP, or -> RUN if irq_pending_i = 1 that cycle.
REQ-024 FLUSH SHALL last exactly WFI_FLUSH_CYCLES cycles absent an interrupt.
REQ-025 SLEEP: core_sleep_o = 1; remains until irq_pending_i = 1, then -> WAKE next cycle.
REQ-026 WAKE: one cycle, core_sleep_o = 0, insn_ready_o = 0; then -> RUN.
REQ-027 SHALL latch irq_pending_i = 1 seen during FLUSH before count 0, aborting sleep at count 0 (-> RUN).
REQ-028 SHALL not change priv_mode_o in FLUSH, SLEEP or WAKE.
REQ-029 All outputs except insn_ready_o SHALL be registered; insn_ready_o is decoded from state only.

Reset
REQ-030 While rst_ni = 0 at a clock edge: state RUN, priv_mode_o = 2'b11, counter 0, all pulse, flush and sleep outputs 0.
REQ-031 SHALL force insn_ready_o = 0 while rst_ni = 0.
REQ-032 Reset asserted in any state (incl. mid-FLUSH or SLEEP) SHALL abort the operation with no trailing pulses.

Configuration
REQ-033 Macro PRIV_UMODE_EN defined: U-Mode supported as specified above.
REQ-034 Macro PRIV_UMODE_EN undefined: priv_mode_o constant 2'b11, MRET leaves mode unchanged, illegal_umode_o and trap_req_o constant 0; WFI/sleep sequencing unchanged.

Verification
REQ-035 Reset, MRET with MPP=00 accepted -> priv_mode_o = 00 next cycle, no pulses.
REQ-036 U-Mode, TW=1, WFI accepted -> illegal_umode_o and trap_req_o high one cycle, priv_mode_o = 11, flush_o stays 0.
REQ-037 M-Mode, WFI_FLUSH_CYCLES=3, WFI accepted, irq low -> flush_o high 3 cycles, core_sleep_o high; irq raised -> sleep drops next cycle, insn_ready_o high one cycle later.
REQ-038 WFI accepted, irq pulses one cycle in first FLUSH cycle -> no SLEEP entry, RUN after WFI_FLUSH_CYCLES.
REQ-039 rst_ni low for one cycle during SLEEP -> all outputs at reset values, priv_mode_o = 11, insn_ready_o = 1 after release.
REQ-040 Build without PRIV_UMODE_EN, MRET with MPP=00 then TW=1 WFI -> priv_mode_o stays 11, no trap, normal sleep sequence.

Source files
------------

// File: rtl/priv_sleep_ctrl.sv
// Privilege-mode tracker and WFI flush/sleep/wake sequencer for a small core.
// Build option: define PRIV_UMODE_EN to support U-Mode (MRET to U, illegal-instruction traps).
module priv_sleep_ctrl #(
    parameter int unsigned WFI_FLUSH_CYCLES = 2   // legal range 1..15
) (
    input  logic       clk,
    input  logic       rst_ni,
    input  logic       insn_valid_i,
    input  logic       mret_insn_i,
    input  logic       wfi_insn_i,
    input  logic       csr_mstatus_tw_i,
    input  logic [1:0] csr_mstatus_mpp_i,
    input  logic       irq_pending_i,
    output logic       insn_ready_o,
    output logic [1:0] priv_mode_o,
    output logic       illegal_umode_o,
    output logic       trap_req_o,
    output logic       flush_o,
    output logic       core_sleep_o
);

    // state | meaning
    // RUN   | accepting instructions
    // FLUSH | draining pipeline before sleep; flush_o high
    // SLEEP | core clock may be gated until an interrupt is pending
    // WAKE  | one-cycle recovery before returning to RUN
    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_SLEEP = 2'd2,
        S_WAKE  = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WFI_FLUSH_CYCLES - 1);

    state_t     state;
    logic [3:0] drain_cnt;
    logic       irq_seen;
    logic       accept;
    logic       illegal;
    logic       wfi_go;

    assign insn_ready_o = rst_ni & (state == S_RUN);
    assign accept       = insn_valid_i & insn_ready_o;
    assign wfi_go       = accept & wfi_insn_i & ~mret_insn_i & ~illegal;

`ifdef PRIV_UMODE_EN
    logic [1:0] priv_q;
    logic       illegal_q;

    assign illegal = accept & (priv_q != 2'b11) &
                     (mret_insn_i | (csr_mstatus_tw_i & wfi_insn_i));

    // accept is only possible in RUN, so the mode is frozen everywhere else
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            priv_q    <= 2'b11;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal;
            if (illegal) begin
                priv_q <= 2'b11;
            end else if (accept && mret_insn_i) begin
                priv_q <= (csr_mstatus_mpp_i == 2'b11) ? 2'b11 : 2'b00;
            end
        end
    end

    assign priv_mode_o     = priv_q;
    assign illegal_umode_o = illegal_q;
    assign trap_req_o      = illegal_q;
`else
    logic unused_csr;

    assign illegal         = 1'b0;
    assign priv_mode_o     = 2'b11;
    assign illegal_umode_o = 1'b0;
    assign trap_req_o      = 1'b0;
    assign unused_csr      = ^{csr_mstatus_tw_i, csr_mstatus_mpp_i};
`endif

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            state        <= S_RUN;
            drain_cnt    <= 4'd0;
            irq_seen     <= 1'b0;
            flush_o      <= 1'b0;
            core_sleep_o <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (wfi_go) begin
                        state     <= S_FLUSH;
                        drain_cnt <= CNT_LOAD;
                        irq_seen  <= 1'b0;
                        flush_o   <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (drain_cnt == 4'd0) begin
                        flush_o  <= 1'b0;
                        irq_seen <= 1'b0;
                        // an interrupt at any point of the drain cancels the sleep
                        if (irq_pending_i || irq_seen) begin
                            state <= S_RUN;
                        end else begin
                            state        <= S_SLEEP;
                            core_sleep_o <= 1'b1;
                        end
                    end else begin
                        drain_cnt <= drain_cnt - 4'd1;
                        if (irq_pending_i) begin
                            irq_seen <= 1'b1;
                        end
                    end
                end
                S_SLEEP: begin
                    if (irq_pending_i) begin
                        state        <= S_WAKE;
                        core_sleep_o <= 1'b0;
                    end
                end
                S_WAKE: begin
                    state <= S_RUN;
                end
                default: begin
                    state <= S_RUN;
                end
            endcase
        end
    end

endmodule
